// File: rtl/mem_pkg.sv
// Shared encodings for the IF/LSU data-memory arbiter: access types,
// response owner and response FSM states.
package mem_pkg;

   localparam int unsigned ADDR_W_DEF = 8;

   typedef enum logic [2:0] {
      LT_LB  = 3'b000,
      LT_LBU = 3'b001,
      LT_LH  = 3'b010,
      LT_LHU = 3'b011,
      LT_LW  = 3'b100
   } load_type_e;

   typedef enum logic [1:0] {
      ST_SB = 2'b00,
      ST_SH = 2'b01,
      ST_SW = 2'b10
   } store_type_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RESP = 1'b1
   } resp_state_e;

endpackage

// File: rtl/mem_align_chk.sv
// Flags an access whose byte address is not a multiple of its access size.
// Only the two low address bits matter, so only those are taken.
module mem_align_chk
   import mem_pkg::*;
(
   input  logic [1:0] i_addr_lsb,
   input  logic       i_is_fetch,
   input  logic       i_we,
   input  logic [2:0] i_load_type,
   input  logic [1:0] i_store_type,
   output logic       o_misaligned
);

   always_comb begin
      o_misaligned = 1'b0;
      if (i_is_fetch) begin
         o_misaligned = (i_addr_lsb != 2'b00);
      end else if (i_we) begin
         case (i_store_type)
            ST_SH:   o_misaligned = i_addr_lsb[0];
            ST_SW:   o_misaligned = (i_addr_lsb != 2'b00);
            default: o_misaligned = 1'b0;
         endcase
      end else begin
         case (i_load_type)
            LT_LH, LT_LHU: o_misaligned = i_addr_lsb[0];
            LT_LW:         o_misaligned = (i_addr_lsb != 2'b00);
            default:       o_misaligned = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data memory between instruction fetch and the LSU: LSU priority,
// starvation guard for IF, misalignment rejection, one-cycle registered response.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 3,
   parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [31:0]       if_rdata_o,
   output logic              if_err_o,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [31:0]       lsu_wdata_i,
   input  logic [2:0]        lsu_load_type_i,
   input  logic [1:0]        lsu_store_type_i,
   output logic              lsu_gnt_o,
   output logic              lsu_rvalid_o,
   output logic [31:0]       lsu_rdata_o,
   output logic              lsu_err_o,
   output logic              mem_rd_en_o,
   output logic              mem_wr_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wr_data_o,
   output logic [2:0]        mem_load_type_o,
   output logic [1:0]        mem_store_type_o,
   input  logic [31:0]       mem_rd_data_i
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic        w_if_mis;
   logic        w_lsu_mis;
   logic        w_if_force;
   logic        w_if_gnt;
   logic        w_lsu_gnt;
   logic        w_any_gnt;
   logic        w_cap_err;
   logic [31:0] w_cap_data;

   logic [3:0]  r_starve_cnt;
   resp_state_e r_state;
   resp_state_e w_state_nxt;
   owner_e      r_owner;
   logic        r_err;
   logic [31:0] r_rdata;

   mem_align_chk u_if_align (
      .i_addr_lsb   (if_addr_i[1:0]),
      .i_is_fetch   (1'b1),
      .i_we         (1'b0),
      .i_load_type  (LT_LW),
      .i_store_type (ST_SB),
      .o_misaligned (w_if_mis)
   );

   mem_align_chk u_lsu_align (
      .i_addr_lsb   (lsu_addr_i[1:0]),
      .i_is_fetch   (1'b0),
      .i_we         (lsu_we_i),
      .i_load_type  (lsu_load_type_i),
      .i_store_type (lsu_store_type_i),
      .o_misaligned (w_lsu_mis)
   );

   assign w_if_force = (r_starve_cnt == LIMIT);

   // Reset gates the grants, which in turn suppresses every memory strobe.
   always_comb begin
      w_if_gnt  = 1'b0;
      w_lsu_gnt = 1'b0;
      if (rst_n) begin
         if (lsu_req_i && !(if_req_i && w_if_force)) begin
            w_lsu_gnt = 1'b1;
         end else if (if_req_i) begin
            w_if_gnt = 1'b1;
         end
      end
   end

   assign w_any_gnt = w_if_gnt || w_lsu_gnt;
   assign if_gnt_o  = w_if_gnt;
   assign lsu_gnt_o = w_lsu_gnt;

   always_comb begin
      mem_rd_en_o      = 1'b0;
      mem_wr_en_o      = 1'b0;
      mem_addr_o       = '0;
      mem_wr_data_o    = '0;
      mem_load_type_o  = '0;
      mem_store_type_o = '0;
      if (w_if_gnt && !w_if_mis) begin
         mem_rd_en_o     = 1'b1;
         mem_addr_o      = if_addr_i;
         mem_load_type_o = LT_LW;
      end else if (w_lsu_gnt && !w_lsu_mis) begin
         mem_addr_o = lsu_addr_i;
         if (lsu_we_i) begin
            mem_wr_en_o      = 1'b1;
            mem_wr_data_o    = lsu_wdata_i;
            mem_store_type_o = lsu_store_type_i;
         end else begin
            mem_rd_en_o     = 1'b1;
            mem_load_type_o = lsu_load_type_i;
         end
      end
   end

   assign w_cap_err  = w_if_gnt ? w_if_mis : w_lsu_mis;
   assign w_cap_data = mem_rd_en_o ? mem_rd_data_i : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (!if_req_i || w_if_gnt) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = S_IDLE;
      case (r_state)
         S_IDLE:  w_state_nxt = w_any_gnt ? S_RESP : S_IDLE;
         S_RESP:  w_state_nxt = w_any_gnt ? S_RESP : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner <= OWN_IF;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else if (w_any_gnt) begin
         r_owner <= w_if_gnt ? OWN_IF : OWN_LSU;
         r_err   <= w_cap_err;
         r_rdata <= w_cap_data;
      end
   end

   // Error and data are masked to the owner so idle outputs read as zero.
   assign if_rvalid_o  = (r_state == S_RESP) && (r_owner == OWN_IF);
   assign lsu_rvalid_o = (r_state == S_RESP) && (r_owner == OWN_LSU);
   assign if_err_o     = if_rvalid_o && r_err;
   assign lsu_err_o    = lsu_rvalid_o && r_err;
   assign if_rdata_o   = if_rvalid_o ? r_rdata : '0;
   assign lsu_rdata_o  = lsu_rvalid_o ? r_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 256-byte memory device and a
// transaction-level reference model checked every cycle.
module tb_mem_arbiter;

   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [7:0]  if_addr = '0;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        lsu_req = 1'b0;
   logic        lsu_we = 1'b0;
   logic [7:0]  lsu_addr = '0;
   logic [31:0] lsu_wdata = '0;
   logic [2:0]  lsu_lt = '0;
   logic [1:0]  lsu_st = '0;
   logic        lsu_gnt, lsu_rvalid, lsu_err;
   logic [31:0] lsu_rdata;
   logic        mem_rd_en, mem_wr_en;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wr_data;
   logic [2:0]  mem_lt;
   logic [1:0]  mem_st;
   logic [31:0] mem_rd_data;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] dmem    [256];
   logic [7:0] ref_mem [256];

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
      .lsu_wdata_i(lsu_wdata), .lsu_load_type_i(lsu_lt), .lsu_store_type_i(lsu_st),
      .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
      .lsu_err_o(lsu_err),
      .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
      .mem_wr_data_o(mem_wr_data), .mem_load_type_o(mem_lt),
      .mem_store_type_o(mem_st), .mem_rd_data_i(mem_rd_data)
   );

   // Memory device: little-endian, asynchronous read, synchronous write.
   always_comb begin
      mem_rd_data = '0;
      case (mem_lt)
         3'b000: mem_rd_data = {{24{dmem[mem_addr][7]}}, dmem[mem_addr]};
         3'b001: mem_rd_data = {24'h0, dmem[mem_addr]};
         3'b010: mem_rd_data = {{16{dmem[mem_addr+8'd1][7]}}, dmem[mem_addr+8'd1], dmem[mem_addr]};
         3'b011: mem_rd_data = {16'h0, dmem[mem_addr+8'd1], dmem[mem_addr]};
         3'b100: mem_rd_data = {dmem[mem_addr+8'd3], dmem[mem_addr+8'd2],
                                dmem[mem_addr+8'd1], dmem[mem_addr]};
         default: mem_rd_data = '0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_wr_en) begin
         dmem[mem_addr] <= mem_wr_data[7:0];
         if (mem_st != 2'b00) dmem[mem_addr+8'd1] <= mem_wr_data[15:8];
         if (mem_st == 2'b10) begin
            dmem[mem_addr+8'd2] <= mem_wr_data[23:16];
            dmem[mem_addr+8'd3] <= mem_wr_data[31:24];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pre(input int i);
      return 8'(i) ^ 8'h5A;
   endfunction

   // ---------------- reference model ----------------
   function automatic int acc_size(input bit fetch, input bit we, input bit [2:0] lt, input bit [1:0] st);
      if (fetch) return 4;
      if (we) return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : (st == 2'd2) ? 4 : 1;
      if (lt == 3'd2 || lt == 3'd3) return 2;
      if (lt == 3'd4) return 4;
      return 1;
   endfunction

   function automatic logic [31:0] m_load(input int a, input bit [2:0] lt);
      int n;
      logic [31:0] v;
      n = (lt == 3'd4) ? 4 : (lt == 3'd2 || lt == 3'd3) ? 2 : 1;
      v = 0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(a + k) % 256]) << (8 * k));
      if (lt == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (lt == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   int          m_starve = 0;
   bit          m_rv_if = 0, m_rv_lsu = 0, m_err = 0;
   logic [31:0] m_rdata = 0;

   always @(negedge clk) begin : model
      bit e_if, e_lsu, mis_if, mis_lsu, lsu_wins;
      bit em_rd, em_wr;
      logic [7:0] em_addr;
      logic [31:0] em_wd, nd;
      logic [2:0] em_lt;
      logic [1:0] em_st;
      int sz;

      chk("if_rvalid",  32'(if_rvalid),  32'(m_rv_if));
      chk("if_err",     32'(if_err),     32'(m_rv_if & m_err));
      chk("if_rdata",   if_rdata,        m_rv_if ? m_rdata : 32'h0);
      chk("lsu_rvalid", 32'(lsu_rvalid), 32'(m_rv_lsu));
      chk("lsu_err",    32'(lsu_err),    32'(m_rv_lsu & m_err));
      chk("lsu_rdata",  lsu_rdata,       m_rv_lsu ? m_rdata : 32'h0);

      lsu_wins = lsu_req && !(if_req && m_starve == LIMIT);
      e_lsu = rst_n && lsu_wins;
      e_if  = rst_n && if_req && !lsu_wins;
      mis_if  = (int'(if_addr) % 4) != 0;
      sz      = acc_size(0, lsu_we, lsu_lt, lsu_st);
      mis_lsu = (int'(lsu_addr) % sz) != 0;

      em_rd = 0; em_wr = 0; em_addr = 0; em_wd = 0; em_lt = 0; em_st = 0;
      if (e_if && !mis_if) begin
         em_rd = 1; em_addr = if_addr; em_lt = 3'd4;
      end else if (e_lsu && !mis_lsu) begin
         em_addr = lsu_addr;
         if (lsu_we) begin em_wr = 1; em_wd = lsu_wdata; em_st = lsu_st; end
         else begin em_rd = 1; em_lt = lsu_lt; end
      end
      chk("if_gnt",    32'(if_gnt),    32'(e_if));
      chk("lsu_gnt",   32'(lsu_gnt),   32'(e_lsu));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(em_rd));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(em_wr));
      chk("mem_addr",  32'(mem_addr),  32'(em_addr));
      chk("mem_wdata", mem_wr_data,    em_wd);
      chk("mem_ltype", 32'(mem_lt),    32'(em_lt));
      chk("mem_stype", 32'(mem_st),    32'(em_st));

      if (!rst_n) begin
         m_starve = 0; m_rv_if = 0; m_rv_lsu = 0; m_err = 0; m_rdata = 0;
      end else begin
         nd = 0;
         if (e_if && !mis_if) nd = m_load(int'(if_addr), 3'd4);
         if (e_lsu && !mis_lsu && !lsu_we) nd = m_load(int'(lsu_addr), lsu_lt);
         if (e_lsu && !mis_lsu && lsu_we)
            for (int k = 0; k < sz; k++) ref_mem[(int'(lsu_addr) + k) % 256] = lsu_wdata[8*k +: 8];
         m_rv_if  = e_if;
         m_rv_lsu = e_lsu;
         if (e_if || e_lsu) begin
            m_err   = e_if ? mis_if : mis_lsu;
            m_rdata = nd;
         end
         if (!if_req || e_if) m_starve = 0;
         else if (m_starve < LIMIT) m_starve = m_starve + 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      if_req = 0; lsu_req = 0; lsu_we = 0;
   endtask

   task automatic lsu_op(input bit we, input logic [7:0] a, input logic [31:0] d,
                         input logic [2:0] lt, input logic [1:0] st);
      lsu_req = 1; lsu_we = we; lsu_addr = a; lsu_wdata = d; lsu_lt = lt; lsu_st = st;
   endtask

   logic [7:0] g_if, g_lsu;
   logic [3:0] g4;

   initial begin
      for (int i = 0; i < 256; i++) begin dmem[i] = pre(i); ref_mem[i] = pre(i); end
      dmem[8'h10] = 8'h44; dmem[8'h11] = 8'h33; dmem[8'h12] = 8'h22; dmem[8'h13] = 8'h11;
      ref_mem[16] = 8'h44; ref_mem[17] = 8'h33; ref_mem[18] = 8'h22; ref_mem[19] = 8'h11;
      repeat (2) step();
      rst_n = 1;
      step();

      // IF-only fetch
      if_req = 1; if_addr = 8'h10;
      @(negedge clk); chk("t1_if_gnt", 32'(if_gnt), 32'd1);
      step(); idle();
      @(negedge clk); chk("t1_if_rdata", if_rdata, 32'h1122_3344);
      step();

      // Store then loads, back-to-back
      lsu_op(1, 8'h20, 32'hDEAD_BEEF, 3'b000, 2'b10); step();
      lsu_op(0, 8'h22, 0, 3'b010, 2'b00);
      @(negedge clk); chk("t2_lsu_rvalid_sw", 32'(lsu_rvalid), 32'd1);
      step();
      lsu_op(0, 8'h23, 0, 3'b000, 2'b00);
      @(negedge clk); chk("t2_lh", lsu_rdata, 32'hFFFF_DEAD);
      step();
      lsu_op(0, 8'h22, 0, 3'b011, 2'b00); step();
      lsu_op(1, 8'h31, 32'h0000_0077, 3'b000, 2'b00); step();
      lsu_op(1, 8'h32, 32'h0000_ABCD, 3'b000, 2'b01); step();
      lsu_op(0, 8'h30, 0, 3'b100, 2'b00); step();
      lsu_op(0, 8'h33, 0, 3'b001, 2'b00); step();
      idle(); step();

      // Contention
      if_req = 1; if_addr = 8'h10; lsu_op(0, 8'h20, 0, 3'b100, 2'b00);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); g_if[i] = if_gnt; g_lsu[i] = lsu_gnt;
         step();
      end
      chk("t3_if_pattern",  32'(g_if),  32'h88);
      chk("t3_lsu_pattern", 32'(g_lsu), 32'h77);
      idle(); step();

      // Misaligned accesses
      lsu_op(0, 8'h21, 0, 3'b100, 2'b00);
      @(negedge clk); chk("t4_lw_gnt", 32'(lsu_gnt), 32'd1); chk("t4_lw_rd_en", 32'(mem_rd_en), 32'd0);
      step();
      lsu_op(1, 8'h05, 32'h0000_AAAA, 3'b000, 2'b01);
      @(negedge clk); chk("t4_lw_err", 32'(lsu_err), 32'd1); chk("t4_lw_rdata", lsu_rdata, 32'd0);
      step();
      lsu_op(0, 8'h23, 0, 3'b010, 2'b00); step();
      idle(); if_req = 1; if_addr = 8'h12; step();
      idle(); step();
      chk("t4_sh_mem5", 32'(dmem[5]), 32'(pre(5)));
      chk("t4_sh_mem6", 32'(dmem[6]), 32'(pre(6)));

      // Reset during a store grant cycle
      if_req = 1; if_addr = 8'h14; lsu_op(0, 8'h40, 0, 3'b100, 2'b00);
      step(); step();
      lsu_op(1, 8'h50, 32'h5A5A_5A5A, 3'b000, 2'b10); rst_n = 0;
      @(negedge clk); chk("t5_wr_en", 32'(mem_wr_en), 32'd0); chk("t5_gnt", 32'(lsu_gnt), 32'd0);
      step();
      rst_n = 1; lsu_op(0, 8'h40, 0, 3'b100, 2'b00);
      @(negedge clk); chk("t5_rvalid", 32'(lsu_rvalid | if_rvalid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         g4[i] = if_gnt;
         step();
      end
      chk("t5_starve_restart", 32'(g4), 32'h8);
      chk("t5_mem50", 32'(dmem[8'h50]), 32'(pre(8'h50)));
      chk("t5_mem53", 32'(dmem[8'h53]), 32'(pre(8'h53)));
      idle(); step(); step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
